// File: rtl/riscv_mem_arb_if.sv
// Fetch, load/store and memory-side bus bundle for riscv_mem_arb.
interface riscv_mem_arb_if;
  // fetch side
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  // load/store side
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_be;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  // memory side
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        bus_err;

  // arbiter view
  modport master (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ready,
    output bus_err
  );

  // requester/memory environment view
  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ready,
    input  bus_err
  );
endinterface

// File: rtl/riscv_mem_arb.sv
// Single-port memory arbiter between instruction fetch and load/store,
// with load/store priority, fetch starvation guard and a busy watchdog.
module riscv_mem_arb #(
  parameter int unsigned MAX_LS_STREAK = 4,
  parameter int unsigned TIMEOUT       = 16
) (
  input  logic            clk,
  input  logic            reset,
  riscv_mem_arb_if.master bus
);

  localparam int unsigned SW = $clog2(MAX_LS_STREAK + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic          if_gnt_q, if_gnt_d;
  logic          ls_gnt_q, ls_gnt_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic          ls_rvalid_q, ls_rvalid_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   ls_rdata_q, ls_rdata_d;
  logic          bus_err_q, bus_err_d;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      wdog_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      wdog_q      <= wdog_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_gnt_q    <= if_gnt_d;
      ls_gnt_q    <= ls_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Arbitration, transaction tracking and completion generation
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    wdog_d      = wdog_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_gnt_d    = 1'b0;
    ls_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    bus_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // fetch wins only once load/store has used up its streak
        if (bus.ls_req && !(bus.if_req && streak_q == SW'(MAX_LS_STREAK))) begin
          state_d     = BUSY_LS;
          ls_gnt_d    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.ls_we;
          mem_addr_d  = bus.ls_addr;
          mem_wdata_d = bus.ls_wdata;
          mem_be_d    = bus.ls_be;
          wdog_d      = '0;
          streak_d    = bus.if_req ? streak_q + SW'(1) : '0;
        end else if (bus.if_req) begin
          state_d     = BUSY_IF;
          if_gnt_d    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
          mem_be_d    = '0;
          wdog_d      = '0;
          streak_d    = '0;
        end else begin
          streak_d    = '0;
        end
      end
      BUSY_IF, BUSY_LS: begin
        if (bus.mem_ready || wdog_q == WW'(TIMEOUT - 1)) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          bus_err_d = !bus.mem_ready;
          if (state_q == BUSY_LS) begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = (bus.mem_ready && !mem_we_q) ? bus.mem_rdata : '0;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus.mem_ready ? bus.mem_rdata : '0;
          end
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.if_gnt    = if_gnt_q;
  assign bus.ls_gnt    = ls_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.ls_rvalid = ls_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.bus_err   = bus_err_q;

endmodule
